// File: rtl/alu_seq_arbiter.sv
// Round-robin front end that shares one external ALU between two requesters.
// Each granted operation loads A and B over the operand bus, executes once, and returns the result.
module alu_seq_arbiter #(
  parameter int ALU_WIDTH = 8,
  parameter int ALU_OPS   = 16,
  parameter int REG_SRC_W = 5,
  parameter int A_REG_MAP = 16,
  parameter int B_REG_MAP = 17
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [$clog2(ALU_OPS)-1:0] req0_op,
  input  logic [ALU_WIDTH-1:0]       req0_a,
  input  logic [ALU_WIDTH-1:0]       req0_b,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [$clog2(ALU_OPS)-1:0] req1_op,
  input  logic [ALU_WIDTH-1:0]       req1_a,
  input  logic [ALU_WIDTH-1:0]       req1_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [ALU_WIDTH-1:0]       rsp_result,
  output logic                       rsp_greater,
  output logic                       rsp_equal,
  output logic                       rsp_err,
  output logic [ALU_WIDTH-1:0]       alu_bus,
  output logic [REG_SRC_W-1:0]       alu_reg_src,
  output logic                       alu_en,
  output logic [$clog2(ALU_OPS)-1:0] alu_op,
  input  logic [ALU_WIDTH-1:0]       alu_result,
  input  logic                       cc_greater,
  input  logic                       cc_equal
);

  // state  | meaning
  // IDLE   | waiting for a request; ready offered to the granted requester
  // LOAD_A | operand A on the bus, A register selected
  // LOAD_B | operand B on the bus, B register selected
  // EXEC   | opcode driven, ALU result/flags captured at the end of the cycle
  // RESP   | response held until the consumer takes it

  localparam int OP_W = $clog2(ALU_OPS);
  localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(9);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;

  state_t                 r_state;
  logic                   r_last_grant;
  logic [OP_W-1:0]        r_op;
  logic [ALU_WIDTH-1:0]   r_a;
  logic [ALU_WIDTH-1:0]   r_b;
  logic                   r_id;

  logic                   r_rsp_valid;
  logic                   r_rsp_id;
  logic [ALU_WIDTH-1:0]   r_rsp_result;
  logic                   r_rsp_greater;
  logic                   r_rsp_equal;
  logic                   r_rsp_err;

  logic [ALU_WIDTH-1:0]   r_alu_bus;
  logic [REG_SRC_W-1:0]   r_alu_reg_src;
  logic                   r_alu_en;
  logic [OP_W-1:0]        r_alu_op;

  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_accept;
  logic                   w_sel_id;
  logic [OP_W-1:0]        w_sel_op;
  logic [ALU_WIDTH-1:0]   w_sel_a;
  logic [ALU_WIDTH-1:0]   w_sel_b;
  logic                   w_sel_legal;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE) begin
      w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
      w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
    end
  end

  assign w_accept    = w_gnt0 | w_gnt1;
  assign w_sel_id    = w_gnt1;
  assign w_sel_op    = w_gnt1 ? req1_op : req0_op;
  assign w_sel_a     = w_gnt1 ? req1_a  : req0_a;
  assign w_sel_b     = w_gnt1 ? req1_b  : req0_b;
  assign w_sel_legal = (w_sel_op <= OP_LAST_LEGAL);

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_greater = r_rsp_greater;
  assign rsp_equal   = r_rsp_equal;
  assign rsp_err     = r_rsp_err;

  assign alu_bus     = r_alu_bus;
  assign alu_reg_src = r_alu_reg_src;
  assign alu_en      = r_alu_en;
  assign alu_op      = r_alu_op;

  // ALU-side outputs are loaded one edge ahead so they are valid throughout their state.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_id          <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_greater <= 1'b0;
      r_rsp_equal   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_alu_bus     <= '0;
      r_alu_reg_src <= '0;
      r_alu_en      <= 1'b0;
      r_alu_op      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op         <= w_sel_op;
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_id         <= w_sel_id;
            r_last_grant <= w_sel_id;
            if (w_sel_legal) begin
              r_state       <= LOAD_A;
              r_alu_bus     <= w_sel_a;
              r_alu_reg_src <= REG_SRC_W'(A_REG_MAP);
              r_alu_en      <= 1'b1;
            end else begin
              // Illegal opcodes never touch the ALU.
              r_state       <= RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_id      <= w_sel_id;
              r_rsp_result  <= '0;
              r_rsp_greater <= 1'b0;
              r_rsp_equal   <= 1'b0;
              r_rsp_err     <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          r_state       <= LOAD_B;
          r_alu_bus     <= r_b;
          r_alu_reg_src <= REG_SRC_W'(B_REG_MAP);
          r_alu_en      <= 1'b1;
        end
        LOAD_B: begin
          r_state       <= EXEC;
          r_alu_bus     <= '0;
          r_alu_reg_src <= '0;
          r_alu_en      <= 1'b0;
          r_alu_op      <= r_op;
        end
        EXEC: begin
          r_state       <= RESP;
          r_alu_op      <= '0;
          r_rsp_valid   <= 1'b1;
          r_rsp_id      <= r_id;
          r_rsp_result  <= alu_result;
          r_rsp_greater <= cc_greater;
          r_rsp_equal   <= cc_equal;
          r_rsp_err     <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_rsp_valid   <= 1'b0;
          r_alu_bus     <= '0;
          r_alu_reg_src <= '0;
          r_alu_en      <= 1'b0;
          r_alu_op      <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
- Shares one ALU register/execute unit between two requesters.
- Each request is a complete operation: opcode plus A and B operands.
- The block arbitrates round-robin and drives the ALU operand bus and register-select lines to load the A and B registers. It then issues the opcode, captures the result and condition codes, and returns them on a response port with backpressure.

Parameters:
- ALU_WIDTH, 8, operand/result width.
- ALU_OPS, 16, opcode space; opcode width is $clog2(ALU_OPS) = 4.
- REG_SRC_W, 5, width of the register-select field.
- A_REG_MAP, 16, reg_src code that loads the ALU A register.
- B_REG_MAP, 17, reg_src code that loads the ALU B register.

Ports:
- sysclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  4  requester 0 opcode.
- req0_a  in  ALU_WIDTH  requester 0 A operand.
- req0_b  in  ALU_WIDTH  requester 0 B operand.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  ALU_WIDTH  captured ALU result.
- rsp_greater  out  1  captured cc_greater.
- rsp_equal  out  1  captured cc_equal.
- rsp_err  out  1  opcode was illegal.
- alu_bus  out  ALU_WIDTH  operand bus to the ALU registers.
- alu_reg_src  out  REG_SRC_W  register-select code.
- alu_en  out  1  ALU register-load enable.
- alu_op  out  4  opcode to the ALU.
- alu_result  in  ALU_WIDTH  combinational ALU result.
- cc_greater  in  1  ALU greater flag.
- cc_equal  in  1  ALU equal flag.

Behaviour:
- Ports: one clock, sysclk. Reset is asynchronous and active-high, named reset.
- Opcode map:
  - 0 nop, 1 add, 2 sub, 3 or, 4 and, 5 not, 6 lsl, 7 lsr, 8 asr, 9 cmp.
  - 10-15 are illegal.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational, high only in IDLE for the granted valid requester; at most one ready is high per cycle.
  - Grant rule when both are valid: the requester not granted last. A single valid requester wins outright.
  - On grant: latch op/a/b/id into internal registers and update last_grant.
  - Next state is LOAD_A for a legal op, RESP for an illegal op.
- LOAD_A: alu_bus = a_q, alu_reg_src = A_REG_MAP, alu_en = 1. Next state LOAD_B.
- LOAD_B: alu_bus = b_q, alu_reg_src = B_REG_MAP, alu_en = 1. Next state EXEC.
- EXEC:
  - alu_en = 0, alu_op = op_q.
  - The ALU registers were loaded at the LOAD_B edge, so alu_result, cc_greater and cc_equal are valid this cycle.
  - Register them into rsp_result, rsp_greater, rsp_equal with rsp_err = 0. Next state RESP.
- Illegal op: rsp_result = 0, flags = 0, rsp_err = 1; alu_en is never asserted for it.
- RESP:
  - rsp_valid = 1, and all rsp_* fields stay stable while rsp_ready = 0.
  - When rsp_ready = 1, go to IDLE.
  - No new grant is possible in the RESP cycle, because ready is IDLE-only.
- Outputs outside their active states: alu_bus = 0, alu_reg_src = 0, alu_en = 0, alu_op = 0 (opcode 0 = nop).
- Latency (legal op): accept edge, then LOAD_A, LOAD_B, EXEC, then rsp_valid rises 4 cycles after the accept cycle.
- Latency (illegal op): rsp_valid rises 1 cycle after accept.
- Throughput: at most one operation per 5 cycles with rsp_ready held high.
- Requester contract: reqN_op/a/b stay stable while reqN_valid is high and reqN_ready is low. A requester may drop valid without being served.
- Reset values: state IDLE, last_grant = 1 (requester 0 wins the first tie), all rsp_* = 0, latched op/a/b/id = 0, all ALU-side outputs = 0.
- Reset mid-operation: the in-flight operation is discarded with no response. ALU-side outputs go to 0 immediately (asynchronously). ALU register contents are unspecified afterward.

Test Plan:
- Add, single requester: req0 add a=0x05 b=0x03, rsp_ready=1 → alu_en high exactly 2 cycles with alu_reg_src 16 then 17, alu_bus 0x05 then 0x03; rsp_valid 4 cycles after accept with result 0x08, id 0, err 0.
- Tie after reset: both requesters valid (req0 sub 0x09,0x04; req1 or 0xF0,0x0F) → req0 served first (0x05, id 0), then req1 (0xFF, id 1); with both held valid, grants alternate 0,1,0.
- Compare: req1 cmp a=0x10 b=0x10 → rsp_equal 1, rsp_greater 0, rsp_result 0. Then cmp a=0x20 b=0x10 → greater 1, equal 0.
- Backpressure: rsp_ready low for 3 cycles during RESP → rsp fields stable, both req*_ready stay 0; state returns to IDLE the cycle after rsp_ready rises.
- Illegal op: req0 op 4'b1100 → rsp_valid 1 cycle after accept with err 1, result 0; alu_en never high.
- Mid-operation reset: reset asserted during LOAD_B → alu_en and alu_bus 0 within the same cycle; no rsp_valid; the next request after release completes normally.
